writeback_queue: RTL



---
 rtl/writeback_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// In-order writeback queue that merges load and ALU results into one register-file write port.
// Optional decode forwarding from queued entries is enabled by defining WB_QUEUE_FORWARD_EN.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                         clock,
  input  logic                         Reset,
  input  logic                         mem_valid,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         mem_ready,
  input  logic                         alu_valid,
  input  logic [ADDR_W-1:0]            alu_addr,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         alu_ready,
  output logic                         reg_write_enable,
  output logic [ADDR_W-1:0]            reg_write_address,
  output logic [DATA_W-1:0]            write_data,
  input  logic [ADDR_W-1:0]            read_register_1,
  input  logic [ADDR_W-1:0]            read_register_2,
  output logic                         fwd_hit_1,
  output logic [DATA_W-1:0]            fwd_data_1,
  output logic                         fwd_hit_2,
  output logic [DATA_W-1:0]            fwd_data_2,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic              not_full;
  logic              push_fire;
  logic              do_push;
  logic              do_pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  assign not_full  = (count_q < CNT_W'(DEPTH));
  assign mem_ready = !Reset && not_full;
  assign alu_ready = !Reset && not_full && !mem_valid;

  // Loads win arbitration; a register-0 write is acknowledged but never stored.
  assign push_fire = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_addr = mem_valid ? mem_addr : alu_addr;
  assign push_data = mem_valid ? mem_data : alu_data;
  assign do_push   = push_fire && (push_addr != '0);
  assign do_pop    = (count_q != '0);

  assign reg_write_enable  = do_pop;
  assign reg_write_address = do_pop ? addr_q[head_q] : '0;
  assign write_data        = do_pop ? data_q[head_q] : '0;
  assign pending_count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (do_push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + 1'b1;
    end
    if (do_pop) begin
      head_d = head_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted as occupied.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

`ifdef WB_QUEUE_FORWARD_EN
  // Walk oldest to youngest so the last match found is the youngest queued write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((read_register_1 != '0) && (addr_q[idx] == read_register_1)) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = data_q[idx];
        end
        if ((read_register_2 != '0) && (addr_q[idx] == read_register_2)) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_read_regs;
  assign unused_read_regs = ^{read_register_1, read_register_2};
  assign fwd_hit_1  = 1'b0;
  assign fwd_data_1 = '0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_2 = '0;
`endif

endmodule
